// File: rtl/diff_restore_if.sv
// Operand/result handshake bundle for the bit-serial difference restorer.
// The producer/consumer side uses master; the datapath uses slave.
interface diff_restore_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] a_out;
    logic             carry_out;

    modport master (
        output in_valid, diff, b, out_ready,
        input  in_ready, out_valid, a_out, carry_out
    );

    modport slave (
        input  in_valid, diff, b, out_ready,
        output in_ready, out_valid, a_out, carry_out
    );
endinterface

// File: rtl/diff_restore.sv
// Restores a minuend from (diff, b) by adding them bit-serially, LSB first,
// one full-adder step per clock; the result is held until the consumer takes it.
module diff_restore #(
    parameter int WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    diff_restore_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t state, next_state;

    logic [WIDTH-1:0] d_sr, b_sr, res_sr, a_reg;
    logic [WIDTH-1:0] res_nxt;
    logic [CW-1:0]    cnt;
    logic             carry, carry_reg;
    logic             in_ready_reg, out_valid_reg;
    logic             in_ready_nxt, out_valid_nxt;
    logic             accept, release_out, last_bit, sum_bit, carry_nxt;

    assign accept      = bus.in_valid && in_ready_reg;
    assign release_out = out_valid_reg && bus.out_ready;
    assign last_bit    = (cnt == LAST);
    assign sum_bit     = d_sr[0] ^ b_sr[0] ^ carry;
    assign carry_nxt   = (d_sr[0] & b_sr[0]) | (d_sr[0] & carry) | (b_sr[0] & carry);
    assign res_nxt     = {sum_bit, res_sr[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept)      next_state = ADD;
            ADD:     if (last_bit)    next_state = DONE;
            DONE:    if (release_out) next_state = IDLE;
            default:                  next_state = IDLE;
        endcase
    end

    // Handshake flags decode the upcoming state so they line up with it exactly.
    always_comb begin
        in_ready_nxt  = (next_state == IDLE);
        out_valid_nxt = (next_state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            in_ready_reg  <= in_ready_nxt;
            out_valid_reg <= out_valid_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_sr      <= '0;
            b_sr      <= '0;
            res_sr    <= '0;
            cnt       <= '0;
            carry     <= 1'b0;
            a_reg     <= '0;
            carry_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        d_sr   <= bus.diff;
                        b_sr   <= bus.b;
                        res_sr <= '0;
                        cnt    <= '0;
                        carry  <= 1'b0;
                    end
                end
                ADD: begin
                    d_sr   <= d_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_nxt;
                    carry  <= carry_nxt;
                    cnt    <= cnt + CW'(1);
                    // Visible outputs change only as the final bit completes.
                    if (last_bit) begin
                        a_reg     <= res_nxt;
                        carry_reg <= carry_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.a_out     = a_reg;
    assign bus.carry_out = carry_reg;
endmodule
